// File: rtl/up_sampler_4.sv
// Interpolate-by-4 front end: 2-entry input FIFO, phase counter and a registered output stage
// that emits the new sample on phase 0 and zero-stuffed or held samples on phases 1..3.
module up_sampler_4 #(
    parameter int unsigned W          = 18,
    parameter bit          ZERO_STUFF = 1'b1,
    parameter int unsigned GAIN_SHL   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic signed [W-1:0] x_in,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [W-1:0] y,
    output logic [1:0]          y_phase,
    output logic                sym_strobe,
    output logic                underflow
);

    localparam int unsigned WE = W + GAIN_SHL;

    logic signed [W-1:0]  r_mem [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic [1:0]           r_phase;
    logic signed [W-1:0]  r_y;
    logic signed [W-1:0]  r_held;
    logic [1:0]           r_y_phase;
    logic                 r_strobe;
    logic                 r_underflow;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_phase0;
    logic [1:0]           w_phase_nx;
    logic [1:0]           w_count_nx;
    logic signed [W-1:0]  w_head;
    logic signed [WE-1:0] w_ext;
    logic signed [WE-1:0] w_shl;
    logic [GAIN_SHL:0]    w_top;
    logic signed [W-1:0]  w_sat;
    logic signed [W-1:0]  w_load;

    assign x_ready    = (r_count < 2'd2);
    assign w_push     = x_valid && x_ready;
    assign w_phase_nx = r_phase + 2'd1;
    assign w_phase0   = clk_en && (w_phase_nx == 2'd0);
    // Pop uses the pre-edge count, so a sample written this edge is never read this edge.
    assign w_pop      = w_phase0 && (r_count != 2'd0);
    assign w_head     = r_mem[r_rd_ptr];

    assign w_ext = WE'(w_head);
    assign w_shl = w_ext <<< GAIN_SHL;
    assign w_top = w_shl[WE-1:W-1];

    always_comb begin
        w_sat = w_shl[W-1:0];
        if (!((&w_top) || (~|w_top))) begin
            w_sat = w_shl[WE-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    assign w_load = ZERO_STUFF ? w_sat : w_head;

    always_comb begin
        w_count_nx = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nx = r_count + 2'd1;
            2'b01:   w_count_nx = r_count - 2'd1;
            default: w_count_nx = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_phase     <= 2'd3;
            r_y         <= '0;
            r_held      <= '0;
            r_y_phase   <= 2'd0;
            r_strobe    <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count  <= w_count_nx;
            r_strobe <= w_phase0;
            if (w_push) begin
                r_mem[r_wr_ptr] <= x_in;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (clk_en) begin
                r_phase   <= w_phase_nx;
                r_y_phase <= w_phase_nx;
                if (w_phase0) begin
                    if (r_count != 2'd0) begin
                        r_y    <= w_load;
                        r_held <= w_head;
                    end else begin
                        r_y         <= '0;
                        r_held      <= '0;
                        r_underflow <= 1'b1;
                    end
                end else begin
                    r_y <= ZERO_STUFF ? '0 : r_held;
                end
            end
        end
    end

    assign y          = r_y;
    assign y_phase    = r_y_phase;
    assign sym_strobe = r_strobe;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_up_sampler_4.sv
// Directed bench for up_sampler_4: one zero-stuffing and one sample-hold instance share stimulus.
module tb_up_sampler_4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [17:0] x_in;
    logic        x_valid;

    logic        rdy_zs, rdy_hd;
    logic [17:0] y_zs, y_hd;
    logic [1:0]  ph_zs, ph_hd;
    logic        st_zs, st_hd;
    logic        uf_zs, uf_hd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] e1_zs [8] = '{18'h00400, 18'h0, 18'h0, 18'h0, 18'h00800, 18'h0, 18'h0, 18'h0};
    logic [17:0] e1_hd [8] = '{18'h00100, 18'h00100, 18'h00100, 18'h00100,
                               18'h00200, 18'h00200, 18'h00200, 18'h00200};
    logic [17:0] s_in  [5] = '{18'h1FFFF, 18'h20000, 18'h3FFFF, 18'h10000, 18'h2FFFF};
    logic [17:0] s_zs  [5] = '{18'h1FFFF, 18'h20000, 18'h3FFFC, 18'h1FFFF, 18'h20000};

    up_sampler_4 #(.W(18), .ZERO_STUFF(1'b1), .GAIN_SHL(2)) u_zs (
        .clk(clk), .reset(reset), .clk_en(clk_en), .x_in(x_in), .x_valid(x_valid),
        .x_ready(rdy_zs), .y(y_zs), .y_phase(ph_zs), .sym_strobe(st_zs), .underflow(uf_zs)
    );

    up_sampler_4 #(.W(18), .ZERO_STUFF(1'b0), .GAIN_SHL(2)) u_hd (
        .clk(clk), .reset(reset), .clk_en(clk_en), .x_in(x_in), .x_valid(x_valid),
        .x_ready(rdy_hd), .y(y_hd), .y_phase(ph_hd), .sym_strobe(st_hd), .underflow(uf_hd)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; clk_en = 1'b0; x_valid = 1'b0; x_in = '0;
        tick; tick;
        reset = 1'b0;
        n_checks++;
        if ({y_zs, y_hd} !== 36'h0) begin
            n_fail++; $display("FAIL reset_y: got %h/%h want 0/0", y_zs, y_hd);
        end
        n_checks++;
        if ({ph_zs, ph_hd, st_zs, st_hd, uf_zs, uf_hd} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctl: got ph %0d/%0d st %b/%b uf %b/%b want all 0",
                     ph_zs, ph_hd, st_zs, st_hd, uf_zs, uf_hd);
        end
        n_checks++;
        if ({rdy_zs, rdy_hd} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %b%b want 11", rdy_zs, rdy_hd);
        end
    endtask

    task automatic test_interp;
        x_valid = 1'b1; x_in = 18'h00100; tick;
        x_in = 18'h00200; tick;
        x_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clk_en = 1'b1; tick; clk_en = 1'b0;
            n_checks++;
            if (y_zs !== e1_zs[i]) begin
                n_fail++; $display("FAIL interp_zs_y[%0d]: got %h want %h", i, y_zs, e1_zs[i]);
            end
            n_checks++;
            if (y_hd !== e1_hd[i]) begin
                n_fail++; $display("FAIL interp_hd_y[%0d]: got %h want %h", i, y_hd, e1_hd[i]);
            end
            n_checks++;
            if ({ph_zs, ph_hd} !== {2'(i), 2'(i)}) begin
                n_fail++; $display("FAIL interp_phase[%0d]: got %0d/%0d want %0d", i, ph_zs,
                                   ph_hd, i % 4);
            end
            n_checks++;
            if ({st_zs, st_hd} !== {2{(i % 4) == 0}}) begin
                n_fail++; $display("FAIL interp_strobe[%0d]: got %b%b want %b", i, st_zs,
                                   st_hd, (i % 4) == 0);
            end
            tick; tick; tick;
            n_checks++;
            if ({y_zs, y_hd, st_zs, st_hd} !== {e1_zs[i], e1_hd[i], 2'b00}) begin
                n_fail++; $display("FAIL interp_idle_hold[%0d]: got %h/%h st %b%b want %h/%h st 00",
                                   i, y_zs, y_hd, st_zs, st_hd, e1_zs[i], e1_hd[i]);
            end
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) begin
            x_in = s_in[i]; x_valid = 1'b1; tick; x_valid = 1'b0;
            clk_en = 1'b1; tick;
            n_checks++;
            if (y_zs !== s_zs[i]) begin
                n_fail++; $display("FAIL sat_zs[%0d]: got %h want %h", i, y_zs, s_zs[i]);
            end
            n_checks++;
            if (y_hd !== s_in[i]) begin
                n_fail++; $display("FAIL sat_hd_raw[%0d]: got %h want %h", i, y_hd, s_in[i]);
            end
            tick;
            n_checks++;
            if ({y_zs, y_hd} !== {18'h0, s_in[i]}) begin
                n_fail++; $display("FAIL sat_phase1[%0d]: got %h/%h want 0/%h", i, y_zs, y_hd,
                                   s_in[i]);
            end
            tick; tick; clk_en = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        clk_en = 1'b0; x_valid = 1'b1;
        x_in = 18'h0000A; tick;
        x_in = 18'h0000B; tick;
        n_checks++;
        if ({rdy_zs, rdy_hd} !== 2'b00) begin
            n_fail++; $display("FAIL bp_full: got ready %b%b want 00", rdy_zs, rdy_hd);
        end
        x_in = 18'h0000C; tick;
        n_checks++;
        if ({rdy_zs, rdy_hd} !== 2'b00) begin
            n_fail++; $display("FAIL bp_stay_full: got ready %b%b want 00", rdy_zs, rdy_hd);
        end
        clk_en = 1'b1; tick; clk_en = 1'b0;
        n_checks++;
        if ({y_zs, y_hd, rdy_zs, rdy_hd} !== {18'h00028, 18'h0000A, 2'b11}) begin
            n_fail++; $display("FAIL bp_pop: got %h/%h ready %b%b want 00028/0000a ready 11",
                               y_zs, y_hd, rdy_zs, rdy_hd);
        end
        tick; x_valid = 1'b0;
        n_checks++;
        if (rdy_hd !== 1'b0) begin
            n_fail++; $display("FAIL bp_refill: got ready %b want 0", rdy_hd);
        end
        clk_en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick;
            if (i == 4) begin
                n_checks++;
                if ({y_hd, y_zs} !== {18'h0000B, 18'h0002C}) begin
                    n_fail++; $display("FAIL bp_second: got %h/%h want 0000b/0002c", y_hd, y_zs);
                end
            end else if (i == 8) begin
                n_checks++;
                if ({y_hd, y_zs} !== {18'h0000C, 18'h00030}) begin
                    n_fail++; $display("FAIL bp_third: got %h/%h want 0000c/00030", y_hd, y_zs);
                end
            end
        end
        clk_en = 1'b0;
        n_checks++;
        if ({rdy_hd, uf_zs, uf_hd} !== 3'b100) begin
            n_fail++; $display("FAIL bp_end: got ready %b uf %b%b want ready 1 uf 00", rdy_hd,
                               uf_zs, uf_hd);
        end
    endtask

    task automatic test_underflow;
        clk_en = 1'b1; tick;
        n_checks++;
        if ({y_zs, y_hd, st_zs, st_hd, uf_zs, uf_hd} !== {36'h0, 4'b1111}) begin
            n_fail++; $display("FAIL uf_set: got %h/%h st %b%b uf %b%b want 0/0 st 11 uf 11",
                               y_zs, y_hd, st_zs, st_hd, uf_zs, uf_hd);
        end
        tick; tick; tick; clk_en = 1'b0;
        n_checks++;
        if ({uf_zs, uf_hd} !== 2'b11) begin
            n_fail++; $display("FAIL uf_sticky: got %b%b want 11", uf_zs, uf_hd);
        end
        x_in = 18'h00050; x_valid = 1'b1; tick; x_valid = 1'b0;
        clk_en = 1'b1; tick;
        n_checks++;
        if ({y_zs, y_hd, uf_zs, uf_hd} !== {18'h00140, 18'h00050, 2'b11}) begin
            n_fail++; $display("FAIL uf_resume: got %h/%h uf %b%b want 00140/00050 uf 11",
                               y_zs, y_hd, uf_zs, uf_hd);
        end
        tick;
        n_checks++;
        if ({y_zs, y_hd} !== {18'h0, 18'h00050}) begin
            n_fail++; $display("FAIL uf_resume_p1: got %h/%h want 0/00050", y_zs, y_hd);
        end
        tick; tick; clk_en = 1'b0;
    endtask

    task automatic test_mid_reset;
        x_valid = 1'b1; x_in = 18'h00011; tick;
        x_in = 18'h00022; tick; x_valid = 1'b0;
        clk_en = 1'b1; tick; clk_en = 1'b0;
        n_checks++;
        if (y_hd !== 18'h00011) begin
            n_fail++; $display("FAIL mr_first: got %h want 00011", y_hd);
        end
        x_valid = 1'b1; x_in = 18'h00033; tick; x_valid = 1'b0;
        clk_en = 1'b1; tick; tick; clk_en = 1'b0;
        n_checks++;
        if ({ph_hd, rdy_hd} !== {2'd2, 1'b0}) begin
            n_fail++; $display("FAIL mr_pre: got phase %0d ready %b want phase 2 ready 0",
                               ph_hd, rdy_hd);
        end
        reset = 1'b1; tick; reset = 1'b0;
        n_checks++;
        if ({y_zs, y_hd, ph_zs, ph_hd, st_zs, st_hd, uf_zs, uf_hd, rdy_zs, rdy_hd} !==
            {36'h0, 8'h00, 2'b11}) begin
            n_fail++; $display("FAIL mr_cleared: got %h/%h ph %0d/%0d st %b%b uf %b%b rdy %b%b",
                               y_zs, y_hd, ph_zs, ph_hd, st_zs, st_hd, uf_zs, uf_hd, rdy_zs,
                               rdy_hd);
        end
        clk_en = 1'b1; tick; clk_en = 1'b0;
        n_checks++;
        if ({y_zs, y_hd, ph_zs, ph_hd, st_zs, st_hd, uf_zs, uf_hd} !== {36'h0, 4'h0, 4'hF}) begin
            n_fail++; $display("FAIL mr_after: got %h/%h ph %0d/%0d st %b%b uf %b%b",
                               y_zs, y_hd, ph_zs, ph_hd, st_zs, st_hd, uf_zs, uf_hd);
        end
    endtask

    initial begin
        test_reset;
        test_interp;
        test_saturation;
        test_back_to_back;
        test_underflow;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
